// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide unit.
//   state_e   : sequencer FSM states
//   mode_e    : datapath step flavour (shift-add multiply or restoring divide)
//   F3_*      : funct3 encodings of the eight M-extension ops
//   OP_RTYPE / F7_MULDIV : opcode/funct7 pair used by the decoder to spot M-ops
package muldiv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_e;

    typedef enum logic {
        MODE_MUL,
        MODE_DIV
    } mode_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam int unsigned CNT_W = 6;

    // Decoder helper: true for an R-type instruction carrying the M-extension funct7.
    function automatic logic is_muldiv_op(input logic [6:0] opcode, input logic [6:0] funct7);
        return (opcode == OP_RTYPE) && (funct7 == F7_MULDIV);
    endfunction

    // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
    function automatic logic signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is treated as signed by MULH, DIV and REM (MULHSU keeps it unsigned).
    function automatic logic signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: shared accumulator for iterative unsigned multiply/divide.
//   clk, rst      : clock, synchronous active-low reset
//   load          : capture operand magnitudes (acc_hi=0, acc_lo=load_a, opnd=load_b)
//   step, mode    : perform one shift-add (MODE_MUL) or restoring step (MODE_DIV)
//   prod_hi/lo    : 2*XLEN-bit product after XLEN multiply steps
//   quotient      : quotient after XLEN divide steps (shares acc_lo)
//   remainder     : remainder after XLEN divide steps (shares acc_hi)
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  mode_e           mode,
    input  logic [XLEN-1:0] load_a,
    input  logic [XLEN-1:0] load_b,
    output logic [XLEN-1:0] prod_hi,
    output logic [XLEN-1:0] prod_lo,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] acc_hi_q, acc_hi_d;
    logic [XLEN-1:0] acc_lo_q, acc_lo_d;
    logic [XLEN-1:0] opnd_q,   opnd_d;

    // Multiply: add the multiplicand when the multiplier LSB (in acc_lo) is set,
    // then shift {carry, acc_hi, acc_lo} right by one.
    logic [XLEN:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});

    // Divide: shift the next dividend bit into the partial remainder and try the
    // subtract. The partial remainder stays below the divisor, so the difference
    // always fits in XLEN bits and can be taken modulo 2^XLEN.
    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_diff;
    assign div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_diff  = div_shift[XLEN-1:0] - opnd_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        if (load) begin
            acc_hi_d = '0;
            acc_lo_d = load_a;
            opnd_d   = load_b;
        end else if (step) begin
            if (mode == MODE_MUL) begin
                acc_hi_d = mul_sum[XLEN:1];
                acc_lo_d = {mul_sum[0], acc_lo_q[XLEN-1:1]};
            end else begin
                acc_hi_d = div_ge ? div_diff : div_shift[XLEN-1:0];
                acc_lo_d = {acc_lo_q[XLEN-2:0], div_ge};
            end
        end
    end

    // NOTE: operand/accumulator registers are reset too, so post-reset state is fully defined.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
        if (!rst) begin
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
        end else begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
        end
    end

    assign prod_hi   = acc_hi_q;
    assign prod_lo   = acc_lo_q;
    assign quotient  = acc_lo_q;
    assign remainder = acc_hi_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit with sequencing FSM.
//   clk, rst   : clock, synchronous active-low reset
//   start      : EX holds a valid M-op (held while stalled)
//   funct3     : M-op select (MUL..REMU)
//   a, b       : rs1/rs2, sampled only on accept
//   flush      : kill the in-flight op
//   stall      : combinational pipeline freeze
//   done       : one-cycle result-valid pulse
//   result     : valid while done=1, holds last value otherwise
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_e           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [2:0]       funct3_q, funct3_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic [XLEN-1:0] prod_hi, prod_lo, quotient, remainder;

    // Accept-time decode of the incoming operands.
    logic            accept, sa, sb, b_zero, ovf, fast;
    logic [XLEN-1:0] abs_a, abs_b, fast_res, fix_res;
    logic [2*XLEN-1:0] prod_full, prod_fix;

    assign accept = (state_q == S_IDLE) && start && !flush;
    assign sa     = signed_a(funct3) && a[XLEN-1];
    assign sb     = signed_b(funct3) && b[XLEN-1];
    assign abs_a  = sa ? -a : a;
    assign abs_b  = sb ? -b : b;

    // Divide special cases finish straight from IDLE without iterating.
    assign b_zero = (b == '0);
    assign ovf    = ((funct3 == F3_DIV) || (funct3 == F3_REM))
                    && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign fast   = funct3[2] && (b_zero || ovf);

    always_comb begin
        fast_res = '0;
        if (b_zero) fast_res = funct3[1] ? a : '1;
        else        fast_res = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // Sign correction on the unsigned magnitudes, then word/result select.
    assign prod_full = {prod_hi, prod_lo};
    assign prod_fix  = (sign_a_q ^ sign_b_q) ? -prod_full : prod_full;

    always_comb begin
        fix_res = '0;
        if (!funct3_q[2]) begin
            fix_res = (funct3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else if (funct3_q[1]) begin
            fix_res = sign_a_q ? -remainder : remainder;
        end else begin
            fix_res = (sign_a_q ^ sign_b_q) ? -quotient : quotient;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct3_d = funct3_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    funct3_d = funct3;
                    sign_a_d = sa;
                    sign_b_d = sb;
                    cnt_d    = '0;
                    if (fast) begin
                        state_d  = S_DONE;
                        result_d = fast_res;
                    end else begin
                        state_d = funct3[2] ? S_DIV : S_MUL;
                    end
                end
            end
            S_MUL, S_DIV: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN-1)) state_d = S_FIX;
            end
            S_FIX: begin
                result_d = fix_res;
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A flush abandons the op: back to IDLE with the visible result untouched.
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            funct3_q <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            result_q <= result_d;
        end
    end

    muldiv_datapath #(.XLEN(XLEN)) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .step      ((state_q == S_MUL) || (state_q == S_DIV)),
        .mode      ((state_q == S_DIV) ? MODE_DIV : MODE_MUL),
        .load_a    (abs_a),
        .load_b    (abs_b),
        .prod_hi   (prod_hi),
        .prod_lo   (prod_lo),
        .quotient  (quotient),
        .remainder (remainder)
    );

    assign stall  = accept || (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule
